// File: rtl/data_mmio_responder.sv
// Data-port responder: word RAM plus MMIO window (TX FIFO, STATUS, CYCLE, HALT).
// Define DATA_MMIO_CYCLE_COUNTER_EN to build the free-running CYCLE counter.
module data_mmio_responder #(
   parameter int unsigned RAM_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
   parameter int unsigned TXQ_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_we,
   input  logic        data_re,
   output logic [31:0] data_rdata,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        halt,
   output logic [31:0] halt_code
);

   localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int PW = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1;
   localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;
   localparam logic [PW:0] TXQ_FULL = (PW+1)'(TXQ_DEPTH);

   localparam logic [3:0] OFF_TX   = 4'h0;
   localparam logic [3:0] OFF_ST   = 4'h4;
   localparam logic [3:0] OFF_CYC  = 4'h8;
   localparam logic [3:0] OFF_HALT = 4'hC;

   logic [31:0] ram [RAM_WORDS];
   logic [7:0]  txq [TXQ_DEPTH];

   logic          ram_hit;
   logic          mmio_hit;
   logic [3:0]    off;
   logic [AW-1:0] ram_idx;
   logic          wr_en;

   logic sel_tx;
   logic sel_st;
   logic sel_cyc;
   logic sel_halt;

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count;
   logic          ovf;
   logic          full;
   logic          empty;
   logic          push_req;
   logic          push;
   logic          pop;
   logic          ovf_set;
   logic          ovf_clr;

   logic [31:0] status_word;
   logic [31:0] cycle_word;

   // RAM takes precedence so the two hit signals are always exclusive
   assign ram_hit  = {1'b0, data_addr} < RAM_BYTES;
   assign mmio_hit = !ram_hit &&
                     (data_addr[31:4] == MMIO_BASE[31:4]);
   assign off      = data_addr[3:0];
   assign ram_idx  = data_addr[AW+1:2];
   assign wr_en    = (data_we != 4'h0) && !halt;

   assign sel_tx   = mmio_hit && (off == OFF_TX);
   assign sel_st   = mmio_hit && (off == OFF_ST);
   assign sel_cyc  = mmio_hit && (off == OFF_CYC);
   assign sel_halt = mmio_hit && (off == OFF_HALT);

   assign full     = (count == TXQ_FULL);
   assign empty    = (count == '0);
   assign tx_valid = !empty;
   assign tx_data  = tx_valid ? txq[rd_ptr] : 8'h00;

   assign pop      = tx_valid && tx_ready;
   assign push_req = wr_en && sel_tx && data_we[0];
   assign push     = push_req && (!full || pop);
   assign ovf_set  = push_req && full && !pop;
   assign ovf_clr  = wr_en && sel_st &&
                     data_we[0] && data_wdata[2];

   assign status_word = {16'h0000, 8'(count),
                         5'b00000, ovf, empty, full};

   always_comb begin
      data_rdata = 32'h0;
      if (data_re) begin
         unique case (1'b1)
            ram_hit:  data_rdata = ram[ram_idx];
            sel_st:   data_rdata = status_word;
            sel_cyc:  data_rdata = cycle_word;
            sel_halt: data_rdata = halt_code;
            default:  data_rdata = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && ram_hit) begin
         for (int i = 0; i < 4; i++) begin
            if (data_we[i])
               ram[ram_idx][8*i +: 8] <= data_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         txq[wr_ptr] <= data_wdata[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   // a same-cycle overflow beats a clear request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf <= 1'b0;
      else if (ovf_set)
         ovf <= 1'b1;
      else if (ovf_clr)
         ovf <= 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halt      <= 1'b0;
         halt_code <= 32'h0;
      end else if (wr_en && sel_halt) begin
         halt      <= 1'b1;
         halt_code <= data_wdata;
      end
   end

`ifdef DATA_MMIO_CYCLE_COUNTER_EN
   logic [31:0] cycle_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cycle_q <= 32'h0;
      else if (!halt)
         cycle_q <= cycle_q + 32'h1;
   end

   assign cycle_word = cycle_q;
`else
   assign cycle_word = 32'h0;
`endif

endmodule

// File: tb/tb_data_mmio_responder.sv
// Self-checking bench for data_mmio_responder.
// Randomized RAM and FIFO traffic is checked against arrays and queues.
module tb_data_mmio_responder;

   localparam logic [31:0] MB     = 32'h1000_0000;
   localparam logic [31:0] A_TX   = MB + 32'h0;
   localparam logic [31:0] A_ST   = MB + 32'h4;
   localparam logic [31:0] A_CYC  = MB + 32'h8;
   localparam logic [31:0] A_HALT = MB + 32'hC;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_we;
   logic        data_re;
   logic [31:0] data_rdata;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        halt;
   logic [31:0] halt_code;

   int total = 0;
   int bad = 0;

   data_mmio_responder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_we    (data_we),
      .data_re    (data_re),
      .data_rdata (data_rdata),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .halt       (halt),
      .halt_code  (halt_code)
   );

   always #5 clk = ~clk;

   task automatic bus_wr(input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [3:0] be);
      @(negedge clk);
      data_addr = a; data_wdata = d;
      data_we = be; data_re = 1'b0;
      @(posedge clk);
      #1 data_we = 4'h0;
   endtask

   task automatic bus_rd(input logic [31:0] a,
                         output logic [31:0] d);
      @(negedge clk);
      data_addr = a; data_we = 4'h0; data_re = 1'b1;
      #1 d = data_rdata;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; tx_ready = 1'b0;
      data_addr = 32'h0; data_wdata = 32'h0;
      data_we = 4'h0; data_re = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if ({data_rdata, tx_valid, tx_data, halt, halt_code} !== 74'h0) begin
         bad++;
         $display("FAIL reset_vals got rdata=%h v=%b d=%h h=%b hc=%h want all 0",
                  data_rdata, tx_valid, tx_data, halt, halt_code);
      end
   endtask

   task automatic test_cycle_counter;
      logic [31:0] exp10;
`ifdef DATA_MMIO_CYCLE_COUNTER_EN
      exp10 = 32'd10;
`else
      exp10 = 32'd0;
`endif
      @(negedge clk);
      rst_n = 1'b1; data_addr = A_CYC; data_re = 1'b1;
      #1;
      total++;
      if (data_rdata !== 32'h0) begin
         bad++;
         $display("FAIL cycle_first got %h want 0", data_rdata);
      end
      repeat (10) @(negedge clk);
      #1;
      total++;
      if (data_rdata !== exp10) begin
         bad++;
         $display("FAIL cycle_ten got %h want %h", data_rdata, exp10);
      end
   endtask

   task automatic test_ram_bytes;
      logic [31:0] r;
      bus_wr(32'h10, 32'hAABB_CCDD, 4'hF);
      bus_wr(32'h10, 32'h0000_0011, 4'h1);
      bus_rd(32'h10, r);
      total++;
      if (r !== 32'hAABB_CC11) begin
         bad++;
         $display("FAIL ram_be got %h want aabbcc11", r);
      end
      bus_rd(32'h4000, r);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL unmapped got %h want 0", r);
      end
      @(negedge clk);
      data_addr = 32'h10; data_wdata = 32'h1234_5678;
      data_we = 4'hF; data_re = 1'b1;
      #1;
      total++;
      if (data_rdata !== 32'hAABB_CC11) begin
         bad++;
         $display("FAIL rd_during_wr got %h want aabbcc11", data_rdata);
      end
      @(posedge clk);
      #1 data_we = 4'h0; data_re = 1'b0;
      #1;
      total++;
      if (data_rdata !== 32'h0) begin
         bad++;
         $display("FAIL re_low got %h want 0", data_rdata);
      end
      bus_rd(32'h10, r);
      total++;
      if (r !== 32'h1234_5678) begin
         bad++;
         $display("FAIL wr_visible got %h want 12345678", r);
      end
   endtask

   task automatic test_random_ram;
      logic [31:0] m [16];
      logic [31:0] r, d, a;
      logic [3:0]  be;
      int          k;
      for (int i = 0; i < 16; i++) begin
         m[i] = $urandom;
         bus_wr(32'h100 + 32'(i * 4), m[i], 4'hF);
      end
      for (int n = 0; n < 150; n++) begin
         k = $urandom_range(0, 15);
         a = 32'h100 + 32'(k * 4);
         case ($urandom_range(0, 2))
            0: begin
               d = $urandom; be = 4'($urandom);
               bus_wr(a, d, be);
               for (int b = 0; b < 4; b++)
                  if (be[b]) m[k][8*b +: 8] = d[8*b +: 8];
            end
            1: begin
               bus_rd(a, r);
               total++;
               if (r !== m[k]) begin
                  bad++;
                  $display("FAIL rand_ram @%h got %h want %h", a, r, m[k]);
               end
            end
            default: begin
               a = $urandom_range(32'h1000, 32'h0FFF_FFFF);
               bus_rd(a, r);
               total++;
               if (r !== 32'h0) begin
                  bad++;
                  $display("FAIL rand_unmapped @%h got %h want 0", a, r);
               end
            end
         endcase
      end
   endtask

   task automatic test_tx_order;
      logic [31:0] r;
      logic [7:0]  exp [3];
      exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         bus_wr(A_TX, {24'h0, exp[i]}, 4'h1);
      bus_rd(A_ST, r);
      total++;
      if (r[15:8] !== 8'd3) begin
         bad++;
         $display("FAIL tx_count got %0d want 3", r[15:8]);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tx_ready = 1'b1;
         #1;
         total++;
         if ({tx_valid, tx_data} !== {1'b1, exp[i]}) begin
            bad++;
            $display("FAIL tx_order[%0d] got v=%b d=%h want v=1 d=%h",
                     i, tx_valid, tx_data, exp[i]);
         end
      end
      @(negedge clk);
      #1;
      total++;
      if (tx_valid !== 1'b0) begin
         bad++;
         $display("FAIL tx_drained got v=%b want 0", tx_valid);
      end
      tx_ready = 1'b0;
      bus_rd(A_ST, r);
      total++;
      if (r[1] !== 1'b1) begin
         bad++;
         $display("FAIL tx_empty got %h want bit1 set", r);
      end
   endtask

   task automatic test_overflow;
      logic [31:0] r;
      logic [7:0]  exp;
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++)
         bus_wr(A_TX, 32'h60 + 32'(i), 4'h1);
      bus_rd(A_ST, r);
      total++;
      if ({r[15:8], r[2], r[0]} !== {8'd8, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL ovf_set got %h want cnt=8 ovf=1 full=1", r);
      end
      bus_wr(A_ST, 32'h4, 4'h1);
      bus_rd(A_ST, r);
      total++;
      if (r[2] !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clr got %h want ovf=0", r);
      end
      @(negedge clk);
      data_addr = A_TX; data_wdata = 32'h99;
      data_we = 4'h1; data_re = 1'b0; tx_ready = 1'b1;
      @(posedge clk);
      #1 data_we = 4'h0; tx_ready = 1'b0;
      bus_rd(A_ST, r);
      total++;
      if ({r[15:8], r[2]} !== {8'd8, 1'b0}) begin
         bad++;
         $display("FAIL full_pushpop got %h want cnt=8 ovf=0", r);
      end
      for (int i = 0; i < 8; i++) begin
         exp = (i < 7) ? 8'(8'h61 + i) : 8'h99;
         @(negedge clk);
         tx_ready = 1'b1;
         #1;
         total++;
         if ({tx_valid, tx_data} !== {1'b1, exp}) begin
            bad++;
            $display("FAIL ovf_drain[%0d] got v=%b d=%h want %h",
                     i, tx_valid, tx_data, exp);
         end
      end
      @(negedge clk);
      #1;
      total++;
      if (tx_valid !== 1'b0) begin
         bad++;
         $display("FAIL ovf_extra got v=%b d=%h want empty", tx_valid, tx_data);
      end
      tx_ready = 1'b0;
   endtask

   task automatic test_random_fifo;
      logic [7:0] q [$];
      logic       ovf_m;
      logic       psh, rdy, pp;
      int         sz;
      bus_wr(A_ST, 32'h4, 4'h1);
      ovf_m = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         psh = 1'($urandom_range(0, 1));
         rdy = ($urandom_range(0, 3) == 0);
         tx_ready = rdy;
         data_wdata = $urandom;
         data_addr = psh ? A_TX : A_ST;
         data_we = psh ? 4'h1 : 4'h0;
         data_re = !psh;
         #1;
         sz = q.size();
         total++;
         if (tx_valid !== (sz != 0) ||
             (sz != 0 && tx_data !== q[0])) begin
            bad++;
            $display("FAIL rand_fifo_head n=%0d got v=%b d=%h want v=%b d=%h",
                     n, tx_valid, tx_data, sz != 0,
                     (sz != 0) ? q[0] : 8'h0);
         end
         if (!psh) begin
            total++;
            if (data_rdata !== {16'h0, 8'(sz), 5'h0, ovf_m,
                                sz == 0, sz == 8}) begin
               bad++;
               $display("FAIL rand_status n=%0d got %h want cnt=%0d ovf=%b",
                        n, data_rdata, sz, ovf_m);
            end
         end
         pp = (sz != 0) && rdy;
         if (pp) void'(q.pop_front());
         if (psh) begin
            if (sz < 8 || pp) q.push_back(data_wdata[7:0]);
            else ovf_m = 1'b1;
         end
      end
      @(negedge clk);
      data_we = 4'h0; data_re = 1'b0; tx_ready = 1'b1;
      for (int n = 0; n < 12; n++) begin
         #1;
         total++;
         if (tx_valid !== (q.size() != 0) ||
             (q.size() != 0 && tx_data !== q[0])) begin
            bad++;
            $display("FAIL rand_drain n=%0d got v=%b d=%h left=%0d",
                     n, tx_valid, tx_data, q.size());
         end
         if (q.size() != 0) void'(q.pop_front());
         @(negedge clk);
      end
      tx_ready = 1'b0;
   endtask

   task automatic test_halt;
      logic [31:0] r, c1, c2;
      tx_ready = 1'b0;
      bus_wr(32'h0, 32'h1234_5678, 4'hF);
      bus_wr(A_TX, 32'h5A, 4'h1);
      bus_wr(A_HALT, 32'h1, 4'hF);
      @(negedge clk);
      #1;
      total++;
      if ({halt, halt_code} !== {1'b1, 32'h1}) begin
         bad++;
         $display("FAIL halt_set got h=%b hc=%h want 1/1", halt, halt_code);
      end
      bus_wr(32'h0, 32'h55, 4'hF);
      bus_wr(A_HALT, 32'h2, 4'hF);
      bus_wr(A_TX, 32'h77, 4'h1);
      bus_rd(32'h0, r);
      total++;
      if (r !== 32'h1234_5678) begin
         bad++;
         $display("FAIL halt_ram got %h want 12345678", r);
      end
      bus_rd(A_HALT, r);
      total++;
      if (r !== 32'h1 || halt_code !== 32'h1) begin
         bad++;
         $display("FAIL halt_sticky got rd=%h hc=%h want 1", r, halt_code);
      end
      bus_rd(A_ST, r);
      total++;
      if (r[15:8] !== 8'd1) begin
         bad++;
         $display("FAIL halt_nopush got cnt=%0d want 1", r[15:8]);
      end
      bus_rd(A_CYC, c1);
      repeat (5) @(negedge clk);
      bus_rd(A_CYC, c2);
      total++;
      if (c2 !== c1) begin
         bad++;
         $display("FAIL halt_cycle got %h want %h", c2, c1);
      end
      @(negedge clk);
      tx_ready = 1'b1;
      #1;
      total++;
      if ({tx_valid, tx_data} !== {1'b1, 8'h5A}) begin
         bad++;
         $display("FAIL halt_drain got v=%b d=%h want 5a", tx_valid, tx_data);
      end
      @(negedge clk);
      #1;
      total++;
      if (tx_valid !== 1'b0) begin
         bad++;
         $display("FAIL halt_drained got v=%b want 0", tx_valid);
      end
      tx_ready = 1'b0;
   endtask

   task automatic test_reset_midflight;
      logic [31:0] r;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         bus_wr(A_TX, 32'h30 + 32'(i), 4'h1);
      @(negedge clk);
      #1;
      total++;
      if ({halt, tx_valid} !== 2'b01) begin
         bad++;
         $display("FAIL pre_reset got h=%b v=%b want 0/1", halt, tx_valid);
      end
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({tx_valid, tx_data} !== 9'h0) begin
         bad++;
         $display("FAIL async_drop got v=%b d=%h want 0", tx_valid, tx_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus_rd(A_ST, r);
      total++;
      if (r[1] !== 1'b1 || r[15:8] !== 8'd0) begin
         bad++;
         $display("FAIL post_reset got %h want empty cnt=0", r);
      end
   endtask

   initial begin
      test_reset();
      test_cycle_counter();
      test_ram_bytes();
      test_random_ram();
      test_tx_order();
      test_overflow();
      test_random_fifo();
      test_halt();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_mmio_responder.md
# data_mmio_responder

Responder for the CPU data port (`data_addr`, `data_wdata`, `data_we`, `data_re`, `data_rdata`). It combines a word-addressed data RAM with a small MMIO register window at `MMIO_BASE`. The window provides:
- an 8-bit console transmit FIFO with a valid/ready output stream;
- a free-running cycle counter;
- a sticky halt register, which lets programs end simulation and report a result code.

It sits between `rv32i_cpu` and the benches as the data-side memory, alongside instruction memory.

## Interface
Parameters:
- `RAM_WORDS`, 1024: data RAM depth in 32-bit words; RAM occupies byte addresses 0 to `RAM_WORDS*4-1`.
- `MMIO_BASE`, 32'h1000_0000: base byte address of the 16-byte MMIO window.
- `TXQ_DEPTH`, 8: TX FIFO depth in entries; must be a power of two, at least 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_addr` in 32: byte address from the CPU.
- `data_wdata` in 32: store data, already lane-aligned.
- `data_we` in 4: per-byte write enables; nonzero means a write.
- `data_re` in 1: read request.
- `data_rdata` out 32: read data.
- `tx_valid` out 1: FIFO head byte is valid.
- `tx_data` out 8: FIFO head byte.
- `tx_ready` in 1: sink accepts the head byte.
- `halt` out 1: sticky halt flag.
- `halt_code` out 32: value written to HALT.

## Operation
Address decode:
- RAM hit: `data_addr < RAM_WORDS*4`; the word index is `data_addr[31:2]`.
- MMIO hit: `data_addr[31:4] == MMIO_BASE[31:4]`, with offset `data_addr[3:0]`.
- Anything else is unmapped.

Reads (combinational):
- `data_rdata` is 0 when `data_re` is 0, and 0 for unmapped addresses.
- A RAM hit returns the full word. The CPU does byte/half extraction.

Writes (rising edge, when `data_we != 0`):
- RAM: each byte lane i with `data_we[i]` set is updated; other lanes are unchanged.
- Unmapped addresses: writes are dropped.

MMIO map (offsets; undefined offsets read 0 and ignore writes):
- 0x0 TX_DATA (write-only, lane 0 needed):
  - `data_we[0]` set pushes `data_wdata[7:0]`.
  - If the FIFO is full and no pop happens this cycle, the byte is dropped and OVF is set.
  - Reads return 0.
- 0x4 STATUS:
  - Read layout: bit0 = full, bit1 = empty, bit2 = OVF (sticky), bits[15:8] = occupancy count, other bits 0.
  - A write with `data_we[0]` and `data_wdata[2]` set clears OVF.
  - If an overflow and a clear happen in the same cycle, the overflow wins.
- 0x8 CYCLE: read returns the current counter value; writes are ignored.
- 0xC HALT:
  - The first write sets `halt` = 1 and `halt_code` = `data_wdata`.
  - Later writes are ignored until reset.
  - Read returns `halt_code`.

TX FIFO:
- Circular buffer with read/write pointers of `$clog2(TXQ_DEPTH)` bits, plus a count.
- Pop occurs when `tx_valid && tx_ready`.
- A simultaneous push and pop is always accepted, including when the FIFO is full; the count is unchanged.
- Pointers wrap modulo `TXQ_DEPTH`.
- `tx_data` comes from the head entry and is stable while `tx_valid && !tx_ready`.

After `halt` = 1:
- All RAM and MMIO writes are ignored.
- Reads are still served.
- The TX FIFO continues to drain.
- The cycle counter freezes.

## Timing
- Reset values: `data_rdata` 0 (no request), `tx_valid` 0, `tx_data` 0, `halt` 0, `halt_code` 0.
- Reset also clears the FIFO pointers, count, OVF and the cycle counter. RAM contents are not reset.
- Read latency 0: `data_rdata` follows the address in the same cycle.
- A write is visible to a read in the cycle after the write edge.
- A read in the same cycle as a write to the same address returns the old data.
- A push at edge N makes `tx_valid` = 1 from cycle N+1. There is no bypass.
- The cycle counter:
  - is 0 on the first cycle after reset release and increments on each edge until halt;
  - wraps from 0xFFFF_FFFF to 0.
- Reset asserted mid-transfer clears the FIFO immediately; queued bytes are lost and `tx_valid` drops asynchronously.

## Configuration
Macro `DATA_MMIO_CYCLE_COUNTER_EN`:
- Defined: the CYCLE register is implemented as specified.
- Undefined: the counter logic is omitted, CYCLE reads 0, and all other behaviour is unchanged.

## Test plan
- RAM byte enables:
  - Stimulus: write 0xAABBCCDD to 0x10 with `data_we`=4'hF, then 0x00000011 with `data_we`=4'h1.
  - Required: read of 0x10 returns 0xAABBCC11; read of 0x4000 (unmapped) returns 0.
- TX ordering:
  - Stimulus: with `tx_ready`=0, push 0x41, 0x42, 0x43.
  - Required: STATUS count = 3. Raising `tx_ready` yields 0x41, 0x42, 0x43 on consecutive cycles, then `tx_valid`=0 and STATUS empty = 1.
- Overflow:
  - Stimulus: with `tx_ready`=0, push 9 bytes with `TXQ_DEPTH`=8.
  - Required: full = 1 and OVF = 1, and the 9th byte never appears on `tx_data`.
  - Stimulus: write STATUS 0x4.
  - Required: OVF = 0.
  - Stimulus: push while full with `tx_ready`=1.
  - Required: the push is accepted and the count stays 8.
- Halt:
  - Stimulus: write 0x0000_0001 to HALT, then write 0x55 to RAM 0x0 and 0x2 to HALT.
  - Required: `halt`=1, `halt_code`=1, RAM 0x0 unchanged, and CYCLE stays constant on subsequent reads.
- Cycle counter and reset:
  - Required: CYCLE reads 0 in the first cycle after `rst_n` rises and 10 ten cycles later.
  - Stimulus: assert `rst_n` low with 3 bytes queued.
  - Required: `tx_valid` drops immediately; after release STATUS reads empty = 1, count = 0.
